instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the instruction RAM: receives the program as a byte stream from the debug UART receiver and assembles 32-bit words.
- Drives the RAM write port (wea/addra/dina) at consecutive word addresses starting at 0.
- Flags completion once the HALT word is stored, so the debug unit can release the fetch stage (PC starts at 0, increments by 1 per word).

Parameters:
- len, 32, data/address width of the RAM port (word = 4 bytes; len fixed at 32)
- RAM_DEPTH, 2048, number of instruction words; writes beyond it are an error
- HALT_WORD, 32'hFFFFFFFF, word that terminates the program (is itself written)

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- in_start  in  1  one-cycle pulse: begin a load (honoured only in IDLE)
- in_clear  in  1  one-cycle pulse: return from DONE/ERROR to IDLE
- in_rx_data  in  8  received byte
- in_rx_done  in  1  one-cycle strobe, in_rx_data valid
- out_wea  out  1  RAM write enable, one-cycle pulse per word
- out_addra  out  len  RAM word address
- out_dina  out  len  RAM write data
- out_busy  out  1  high in LOAD
- out_done  out  1  high in DONE (program loaded, HALT stored)
- out_error  out  1  high in ERROR (overflow, no HALT within RAM_DEPTH)
- out_word_count  out  len  words written since last start

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; byte counter 0; partial word discarded.
- States: IDLE, LOAD, DONE, ERROR.
  - IDLE: in_start -> LOAD; clears out_word_count and the write pointer to 0.
  - LOAD: bytes accepted. HALT word written -> DONE. Non-HALT word written at address RAM_DEPTH-1 -> ERROR.
  - DONE / ERROR: in_clear -> IDLE; all other inputs ignored.
- in_rx_done outside LOAD: ignored; no state change.
- in_start outside IDLE: ignored.
- in_start and in_clear together: act on in_clear (only meaningful in DONE/ERROR).
- Assembly:
  - 2-bit byte counter; first received byte is the MSB (bits 31:24), the fourth is the LSB (big-endian).
  - On the strobe of the 4th byte at cycle N, in cycle N+1: out_wea=1, out_dina=assembled word, out_addra=write pointer.
  - Write pointer and out_word_count increment at the end of the wea cycle.
  - out_wea is high for exactly one cycle per word.
- Back-to-back: a byte strobe in the wea cycle is accepted as byte 0 of the next word; no byte is lost at one strobe per cycle.
- The state transition to DONE/ERROR takes effect at the end of the wea cycle; out_done/out_error rise in cycle N+2.
- out_addra holds the last written address between writes; it is 0 after reset and after start.
- Width: write pointer compared against RAM_DEPTH-1 at full len width; no wrap-around, ever.
- Reset mid-load: everything returns to reset values; the RAM is not cleared; the host restarts with in_start.

Decomposition:
- Shared package (mips_pkg) holds:
  - the loader state encodings (2-bit localparams IDLE/LOAD/DONE/ERROR)
  - HALT_WORD default
  - RAM_DEPTH default (shared with ram_instrucciones)
- One sub-module, byte_assembler: 8-bit shift-in, 2-bit counter, word_valid pulse, synchronous clear.
- instruction_loader keeps the FSM, write pointer and RAM port registers.

Test Plan:
- Reset, in_start, bytes 24 00 00 05, 24 01 00 07, FF FF FF FF -> writes (0,0x24000005), (1,0x24010007), (2,0xFFFFFFFF); out_done=1 at cycle N+2 after the final byte; out_word_count=3.
- Bytes 01 02 03 04 on consecutive cycles, then 05 06 07 08 on the very next cycles -> wea at addresses 0/1 with 0x01020304/0x05060708; one wea pulse each, no byte dropped.
- RAM_DEPTH=4, 4 non-HALT words -> 4 writes to addresses 0..3, then out_error=1, out_busy=0; a further byte produces no wea; in_clear -> IDLE.
- Bytes before in_start and after DONE -> no wea, counters unchanged; in_start during LOAD -> ignored.
- reset low after 2 bytes of word 1 (asynchronously, mid-cycle) -> outputs 0 immediately; then in_start + full word AA BB CC DD -> write 0xAABBCCDD at address 0.
- DONE, in_clear, in_start, HALT only -> write 0xFFFFFFFF at address 0; out_word_count=1; out_done=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Purpose : shared constants and types for the instruction RAM writer and the RAM itself.
// Latency : n/a (package).
// Backpressure: n/a (package).
// Contents: loader state encodings, default HALT word, default instruction RAM depth.
package mips_pkg;

   // Word width of the instruction RAM port
   localparam int LEN = 32;

   // Default number of instruction words, shared with ram_instrucciones
   localparam int RAM_DEPTH_DEF = 2048;

   // Word that terminates a program; it is itself stored in the RAM
   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

   // Loader state encodings
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [1:0] ERROR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_LOAD  = LOAD,
      ST_DONE  = DONE,
      ST_ERROR = ERROR
   } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Purpose : packs four received bytes into one big-endian 32-bit word (first byte -> bits 31:24).
// Latency : word_valid/word are combinational with the 4th byte strobe (same cycle).
// Backpressure: none; accepts one byte per cycle, every cycle.
// Ports   : clk, reset (async, active-low), clear (sync, drops any partial word),
//           rx_data/rx_done (byte + strobe), word_valid (1-cycle pulse), word (assembled value).
module byte_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [7:0]  rx_data,
   input  logic        rx_done,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  byte_cnt;
   logic [23:0] shift_q;   // the three bytes received so far, oldest in the top byte

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt <= 2'd0;
         shift_q  <= 24'd0;
      end else if (clear) begin
         byte_cnt <= 2'd0;
         shift_q  <= 24'd0;
      end else if (rx_done) begin
         // Counter wraps to 0 on the 4th byte, so the next strobe is byte 0 of a new word
         byte_cnt <= byte_cnt + 2'd1;
         shift_q  <= {shift_q[15:0], rx_data};
      end
   end

   // The 4th byte goes straight into the LSB so the word is ready in its strobe cycle
   assign word_valid = rx_done && !clear && (byte_cnt == 2'd3);
   assign word       = {shift_q, rx_data};

endmodule

// File: rtl/instruction_loader.sv
// Purpose : writes a byte-streamed program into the instruction RAM at word addresses 0,1,2,...
// Latency : 4th byte strobe in cycle N -> wea in N+1; done/error visible in N+2.
// Backpressure: none; one byte per cycle sustained, bytes outside LOAD are dropped.
// Ports   : clk, reset (async, active-low), in_start/in_clear (control pulses),
//           in_rx_data/in_rx_done (UART byte stream), out_wea/out_addra/out_dina (RAM write port),
//           out_busy/out_done/out_error (state flags), out_word_count (words written since start).
module instruction_loader
   import mips_pkg::*;
#(
   parameter int              len       = 32,
   parameter int              RAM_DEPTH = RAM_DEPTH_DEF,
   parameter logic [len-1:0]  HALT_WORD = HALT_WORD_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_start,
   input  logic           in_clear,
   input  logic [7:0]     in_rx_data,
   input  logic           in_rx_done,
   output logic           out_wea,
   output logic [len-1:0] out_addra,
   output logic [len-1:0] out_dina,
   output logic           out_busy,
   output logic           out_done,
   output logic           out_error,
   output logic [len-1:0] out_word_count
);

   // Full-width compare value, so the pointer never aliases and never wraps
   localparam logic [len-1:0] LAST_ADDR = len'(RAM_DEPTH - 1);

   loader_state_t  state;
   logic           start_acc;
   logic           clear_acc;
   logic           asm_rx;
   logic           asm_word_vld;
   logic [len-1:0] asm_word;

   // in_clear has priority over in_start; each is only honoured in its own states
   assign start_acc = (state == ST_IDLE) && in_start && !in_clear;
   assign clear_acc = ((state == ST_DONE) || (state == ST_ERROR)) && in_clear;

   // Bytes only reach the assembler while loading
   assign asm_rx = in_rx_done && (state == ST_LOAD);

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_acc),
      .rx_data    (in_rx_data),
      .rx_done    (asm_rx),
      .word_valid (asm_word_vld),
      .word       (asm_word)
   );

   // out_word_count doubles as the write pointer: both start at 0 on start
   // and both advance at the end of every wea cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         out_wea        <= 1'b0;
         out_addra      <= '0;
         out_dina       <= '0;
         out_busy       <= 1'b0;
         out_done       <= 1'b0;
         out_error      <= 1'b0;
         out_word_count <= '0;
      end else begin
         out_wea <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_acc) begin
                  state          <= ST_LOAD;
                  out_busy       <= 1'b1;
                  out_addra      <= '0;
                  out_word_count <= '0;
               end
            end

            ST_LOAD: begin
               // Terminal decisions use the word currently on the RAM port (the wea cycle)
               if (out_wea) begin
                  out_word_count <= out_word_count + len'(1);
                  if (out_dina == HALT_WORD) begin
                     state    <= ST_DONE;
                     out_busy <= 1'b0;
                     out_done <= 1'b1;
                  end else if (out_addra == LAST_ADDR) begin
                     state     <= ST_ERROR;
                     out_busy  <= 1'b0;
                     out_error <= 1'b1;
                  end
               end
               // A new word needs four strobes, so it never coincides with a wea cycle
               if (asm_word_vld) begin
                  out_wea   <= 1'b1;
                  out_dina  <= asm_word;
                  out_addra <= out_word_count;
               end
            end

            ST_DONE, ST_ERROR: begin
               if (clear_acc) begin
                  state     <= ST_IDLE;
                  out_done  <= 1'b0;
                  out_error <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_start = 1'b0;
   logic        in_clear = 1'b0;
   logic [7:0]  in_rx_data = 8'd0;
   logic        in_rx_done = 1'b0;
   logic        out_wea;
   logic [31:0] out_addra;
   logic [31:0] out_dina;
   logic        out_busy;
   logic        out_done;
   logic        out_error;
   logic [31:0] out_word_count;

   always #5 clk = ~clk;

   instruction_loader #(.len(32), .RAM_DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_start       (in_start),
      .in_clear       (in_clear),
      .in_rx_data     (in_rx_data),
      .in_rx_done     (in_rx_done),
      .out_wea        (out_wea),
      .out_addra      (out_addra),
      .out_dina       (out_dina),
      .out_busy       (out_busy),
      .out_done       (out_done),
      .out_error      (out_error),
      .out_word_count (out_word_count)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  send_q[$];   // bytes still to be sent
   logic [7:0]  tx_q[$];     // bytes sent since the last start
   logic [63:0] obs_q[$];    // {addr, data} seen on the RAM port
   logic [63:0] exp_q[$];
   bit          exp_done;
   bit          exp_err;
   int          exp_cnt;
   int          snap;

   always @(negedge clk)
      if (reset && out_wea) obs_q.push_back({out_addra, out_dina});

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      in_start = 1'b1;
      tick();
      in_start = 1'b0;
   endtask

   task automatic pulse_clear();
      in_clear = 1'b1;
      tick();
      in_clear = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic begin_load();
      obs_q.delete();
      tx_q.delete();
      pulse_start();
   endtask

   // One strobe per byte; up to max_gap idle cycles after each
   task automatic send_bytes(input int max_gap);
      for (int i = 0; i < send_q.size(); i++) begin
         in_rx_data = send_q[i];
         in_rx_done = 1'b1;
         tx_q.push_back(send_q[i]);
         tick();
         in_rx_done = 1'b0;
         repeat ($urandom_range(max_gap, 0)) tick();
      end
      send_q.delete();
   endtask

   task automatic push_word(input logic [31:0] w);
      send_q.push_back(w[31:24]);
      send_q.push_back(w[23:16]);
      send_q.push_back(w[15:8]);
      send_q.push_back(w[7:0]);
   endtask

   // Reference: chop the stream into big-endian words, store them in order from
   // address 0, stop after HALT or after filling the last RAM word.
   task automatic model_load();
      logic [31:0] w;
      exp_q.delete();
      exp_done = 0;
      exp_err  = 0;
      exp_cnt  = 0;
      for (int b = 0; b + 3 < tx_q.size(); b += 4) begin
         if (exp_done || exp_err) break;
         w = {tx_q[b], tx_q[b+1], tx_q[b+2], tx_q[b+3]};
         exp_q.push_back({32'(exp_cnt), w});
         exp_cnt++;
         if (w == HALT) exp_done = 1;
         else if (exp_cnt == DEPTH) exp_err = 1;
      end
   endtask

   task automatic compare_run(input string tag);
      tick(); tick(); tick();
      model_load();
      check_eq({tag, "_nwrites"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check_eq($sformatf("%s_w%0d_addr", tag, i), obs_q[i][63:32], exp_q[i][63:32]);
         check_eq($sformatf("%s_w%0d_data", tag, i), obs_q[i][31:0], exp_q[i][31:0]);
      end
      check_eq({tag, "_done"}, out_done, exp_done);
      check_eq({tag, "_error"}, out_error, exp_err);
      check_eq({tag, "_busy"}, out_busy, !(exp_done || exp_err));
      check_eq({tag, "_count"}, out_word_count, exp_cnt);
      check_eq({tag, "_addra"}, out_addra, (exp_cnt > 0) ? 32'(exp_cnt - 1) : 32'd0);
      check_eq({tag, "_wea_idle"}, out_wea, 1'b0);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check_eq("rst_wea", out_wea, 1'b0);
      check_eq("rst_busy", out_busy, 1'b0);
      check_eq("rst_done", out_done, 1'b0);
      check_eq("rst_error", out_error, 1'b0);
      check_eq("rst_addra", out_addra, 32'd0);
      check_eq("rst_dina", out_dina, 32'd0);
      check_eq("rst_count", out_word_count, 32'd0);
      reset = 1'b1;
      tick();

      // Three-word program ending in HALT, with cycle-exact completion timing
      begin_load();
      check_eq("t1_busy_start", out_busy, 1'b1);
      push_word(32'h2400_0005);
      push_word(32'h2401_0007);
      push_word(HALT);
      send_bytes(0);
      check_eq("t1_wea_n1", out_wea, 1'b1);
      check_eq("t1_addra_n1", out_addra, 32'd2);
      check_eq("t1_dina_n1", out_dina, HALT);
      check_eq("t1_done_n1", out_done, 1'b0);
      tick();
      check_eq("t1_done_n2", out_done, 1'b1);
      check_eq("t1_busy_n2", out_busy, 1'b0);
      compare_run("t1");
      pulse_clear();
      check_eq("t1_clr_done", out_done, 1'b0);

      // Back-to-back words, no idle cycles
      begin_load();
      push_word(32'h0102_0304);
      push_word(32'h0506_0708);
      send_bytes(0);
      compare_run("t2");
      do_reset();

      // Overflow: DEPTH non-HALT words
      begin_load();
      for (int i = 0; i < DEPTH; i++) push_word(32'h1011_1213 + 32'(i));
      send_bytes(1);
      compare_run("t3");
      snap = obs_q.size();
      push_word(32'h5555_5555);
      send_bytes(0);
      tick(); tick();
      check_eq("t3_no_wea_after_err", obs_q.size(), snap);
      check_eq("t3_count_hold", out_word_count, DEPTH);
      pulse_clear();
      check_eq("t3_clr_error", out_error, 1'b0);
      check_eq("t3_clr_busy", out_busy, 1'b0);

      // Bytes in IDLE are ignored; start during LOAD is ignored
      obs_q.delete();
      push_word(32'hDEAD_BEEF);
      send_bytes(0);
      tick(); tick();
      check_eq("t4_idle_no_wea", obs_q.size(), 0);
      check_eq("t4_idle_count", out_word_count, DEPTH);
      begin_load();
      send_q.push_back(8'h11);
      send_q.push_back(8'h22);
      send_bytes(0);
      pulse_start();
      check_eq("t4_start_in_load_busy", out_busy, 1'b1);
      send_q.push_back(8'h33);
      send_q.push_back(8'h44);
      push_word(HALT);
      send_bytes(0);
      compare_run("t4");
      snap = obs_q.size();
      push_word(32'h0000_0001);
      send_bytes(0);
      tick(); tick();
      check_eq("t4_done_no_wea", obs_q.size(), snap);
      check_eq("t4_done_count", out_word_count, 32'd2);
      check_eq("t4_done_hold", out_done, 1'b1);

      // start and clear together: clear wins, back to IDLE
      in_start = 1'b1;
      in_clear = 1'b1;
      tick();
      in_start = 1'b0;
      in_clear = 1'b0;
      tick();
      check_eq("t6_both_busy", out_busy, 1'b0);
      check_eq("t6_both_done", out_done, 1'b0);
      begin_load();
      push_word(HALT);
      send_bytes(0);
      compare_run("t6");
      pulse_clear();

      // Asynchronous reset in the middle of a word
      begin_load();
      push_word(32'h0102_0304);
      send_q.push_back(8'hAB);
      send_q.push_back(8'hCD);
      send_bytes(0);
      tick();
      check_eq("t5_count_before", out_word_count, 32'd1);
      #3 reset = 1'b0;
      #1;
      check_eq("t5_async_busy", out_busy, 1'b0);
      check_eq("t5_async_addra", out_addra, 32'd0);
      check_eq("t5_async_dina", out_dina, 32'd0);
      check_eq("t5_async_count", out_word_count, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      begin_load();
      push_word(32'hAABB_CCDD);
      send_bytes(0);
      compare_run("t5");
      do_reset();

      // Random programs: random words, optional HALT, trailing bytes, random gaps
      for (int it = 0; it < 40; it++) begin
         int nwords;
         int halt_at;
         begin_load();
         nwords  = $urandom_range(5, 1);
         halt_at = $urandom_range(6, 0);
         for (int i = 0; i < nwords; i++)
            push_word((i == halt_at) ? HALT : 32'($urandom));
         repeat ($urandom_range(3, 0)) send_q.push_back(8'($urandom));
         send_bytes($urandom_range(2, 0));
         compare_run($sformatf("rnd%0d", it));
         if (exp_done || exp_err) begin
            pulse_clear();
            check_eq($sformatf("rnd%0d_idle", it), out_done | out_error | out_busy, 1'b0);
         end else begin
            do_reset();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
